stfq_rank_computer: RTL
=======================

Name: stfq_rank_computer

Overview:
- Upstream of the per-flow rank store. Assigns each arriving packet a Start-Time Fair Queueing rank and drives the store's push interface.
- Keeps per-flow last-finish tags and a virtual clock. The virtual clock advances from ranks popped out of the store.
- Two-stage valid/ready pipeline with registered outputs.

Parameters:
- FLOWS, 10, number of flows; width of the one-hot push_flow.
- FW, $clog2(FLOWS), width of the binary flow index.
- LEN_W, 16, packet length width.
- DEF_SHIFT, 0, reset weight shift for every flow.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  packet offered
- in_ready  out  1  packet accepted when in_valid && in_ready
- in_flow  in  FW  binary flow index
- in_len  in  LEN_W  packet length in bytes
- in_value  in  32  payload/handle passed through
- cfg_we  in  1  weight-shift write strobe
- cfg_flow  in  FW  flow being configured
- cfg_shift  in  4  cost = in_len >> cfg_shift
- deq_valid  in  1  rank store pop_valid
- deq_rank  in  32  rank store pop_rank
- out_ready  in  1  downstream can take a push; tie to 1 if unused
- push  out  1  to rank store push
- push_rank  out  32  computed start tag
- push_value  out  32  in_value delayed
- push_flow  out  FLOWS  one-hot of in_flow

Behaviour:
- Reset:
  - S1/S2 valid = 0; push = 0; push_rank = push_value = push_flow = 0.
  - vtime = 0; finish[f] = 0 and shift[f] = DEF_SHIFT for every f.
  - in_ready = 1 in the cycle after reset.
- Reset mid-operation discards all in-flight packets; no push is emitted in the cycle after rst.
- S1 (capture):
  - On accept, register flow, len, value. Set s1_valid.
  - s1 advances when S2 is empty or S2 fires.
  - in_ready = !s1_valid || s1_advance.
- S2 (compute):
  - cost = len >> shift[flow], zero-extended to 32 bits.
  - start = max(vtime, finish[flow]).
  - fin = start + cost, saturating at 0xFFFFFFFF.
  - finish[flow] <= fin when S2 loads.
  - Register push_rank = start, push_value, and push_flow = 1 << flow.
- push = s2_valid && out_ready; S2 fires on push.
- When out_ready = 0, S2 holds and its outputs stay stable; S1 fills, then in_ready drops.
- Latency: accept in cycle N gives push in cycle N+2 when out_ready is held high.
- Throughput: 1 packet/cycle.
- Same-flow back-to-back: the S2 load in cycle N must see the finish[] written in cycle N-1. The table is read combinationally at S2 load, so consecutive same-flow packets chain with no bubble.
- Virtual time:
  - On deq_valid, vtime <= max(vtime, deq_rank). vtime never decreases.
  - deq_valid and an S2 load in the same cycle: the load uses the pre-update vtime.
- Config:
  - cfg_we writes shift[cfg_flow]; the write takes effect from the next cycle.
  - A write in the same cycle as an S2 load of that flow: the load uses the old shift.
- in_flow >= FLOWS is accepted and dropped. No push is emitted and no state changes.
- Saturation: once finish[f] = 0xFFFFFFFF it stays there until reset. Ranks never wrap.

Optional Feature:
- Macro: STFQ_STATS_EN.
- With the macro, add outputs:
  - stat_pkts[31:0]: count of pushes, wrapping.
  - stat_sat[15:0]: count of saturated fin computations, saturating at 0xFFFF.
  - stat_drop[15:0]: count of out-of-range flows, saturating at 0xFFFF.
  - All three counters clear on rst.
- Without the macro, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then flow 2 len 100 shift 0: push in cycle 2 with push_rank 0, push_flow 0x004. finish[2] = 100.
- Flow 2 len 100 three times back-to-back: ranks 0, 100, 200 on consecutive cycles with no bubble.
- cfg shift[1] = 2, then flow 1 len 64 ×2 interleaved with flow 0 len 64 ×2: ranks f1 0, 16 and f0 0, 64.
- deq_valid with deq_rank 500, then flow 3 len 10: rank 500. Next, deq_rank 300: vtime stays 500.
- out_ready low for 3 cycles with 4 packets offered: push_rank/push_value stable; in_ready = 0 after S1 fills; all 4 pushes in order, none lost.
- finish[0] = 0xFFFFFF00, then len 0x200: fin saturates to 0xFFFFFFFF; next rank on flow 0 = 0xFFFFFFFF; stat_sat = 1 when STFQ_STATS_EN is defined.

Source files
------------

// File: rtl/stfq_rank_computer_if.sv
// Packet-in and rank-store push channels of the STFQ rank computer.
// master = upstream/store side, slave = the rank computer itself.
interface stfq_rank_computer_if #(
    parameter int unsigned FLOWS = 10,
    parameter int unsigned FW    = $clog2(FLOWS),
    parameter int unsigned LEN_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [FW-1:0]    in_flow;
    logic [LEN_W-1:0] in_len;
    logic [31:0]      in_value;
    logic             out_ready;
    logic             push;
    logic [31:0]      push_rank;
    logic [31:0]      push_value;
    logic [FLOWS-1:0] push_flow;

    modport master (
        output in_valid, in_flow, in_len, in_value, out_ready,
        input  in_ready, push, push_rank, push_value, push_flow
    );

    modport slave (
        input  in_valid, in_flow, in_len, in_value, out_ready,
        output in_ready, push, push_rank, push_value, push_flow
    );
endinterface

// File: rtl/stfq_rank_computer.sv
// Start-Time Fair Queueing rank computer: two-stage pipeline feeding a per-flow rank store.
// Define STFQ_STATS_EN to add the stat_pkts / stat_sat / stat_drop counters.
module stfq_rank_computer #(
    parameter int unsigned FLOWS     = 10,
    parameter int unsigned FW        = $clog2(FLOWS),
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned DEF_SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    stfq_rank_computer_if.slave  bus,
    input  logic                 cfg_we,
    input  logic [FW-1:0]        cfg_flow,
    input  logic [3:0]           cfg_shift,
    input  logic                 deq_valid,
    input  logic [31:0]          deq_rank
`ifdef STFQ_STATS_EN
    ,
    output logic [31:0]          stat_pkts,
    output logic [15:0]          stat_sat,
    output logic [15:0]          stat_drop
`endif
);

    logic             s1_valid_q;
    logic [FW-1:0]    s1_flow_q;
    logic [LEN_W-1:0] s1_len_q;
    logic [31:0]      s1_value_q;

    logic             s2_valid_q;
    logic [31:0]      rank_q;
    logic [31:0]      value_q;
    logic [FLOWS-1:0] flow_oh_q;

    logic [31:0]      vtime_q;
    logic [31:0]      finish_q [FLOWS];
    logic [3:0]       shift_q  [FLOWS];

    logic             accept;
    logic             flow_ok;
    logic             push;
    logic             s1_advance;
    logic             in_ready;
    logic [3:0]       cur_shift;
    logic [31:0]      cur_finish;
    logic [31:0]      cost;
    logic [31:0]      start;
    logic [32:0]      sum;
    logic             fin_sat;
    logic [31:0]      fin;
    logic [FLOWS-1:0] flow_oh;

    always_comb begin
        push       = s2_valid_q && bus.out_ready;
        s1_advance = s1_valid_q && (!s2_valid_q || push);
        in_ready   = !s1_valid_q || s1_advance;
        accept     = bus.in_valid && in_ready;
        flow_ok    = 32'(bus.in_flow) < FLOWS;
    end

    // finish/shift are read combinationally so a same-flow packet loading right
    // behind another sees the tag written on the previous edge.
    always_comb begin
        cur_shift  = shift_q[s1_flow_q];
        cur_finish = finish_q[s1_flow_q];
        cost       = 32'(s1_len_q >> cur_shift);
        start      = (vtime_q > cur_finish) ? vtime_q : cur_finish;
        sum        = {1'b0, start} + {1'b0, cost};
        fin_sat    = sum[32];
        fin        = fin_sat ? 32'hFFFF_FFFF : sum[31:0];
        flow_oh    = FLOWS'(1) << s1_flow_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_flow_q  <= '0;
            s1_len_q   <= '0;
            s1_value_q <= '0;
        end else begin
            if (s1_advance) begin
                s1_valid_q <= 1'b0;
            end
            // Out-of-range flows are consumed here and never enter the pipeline.
            if (accept && flow_ok) begin
                s1_valid_q <= 1'b1;
                s1_flow_q  <= bus.in_flow;
                s1_len_q   <= bus.in_len;
                s1_value_q <= bus.in_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            rank_q     <= '0;
            value_q    <= '0;
            flow_oh_q  <= '0;
            for (int f = 0; f < FLOWS; f++) begin
                finish_q[f] <= '0;
            end
        end else if (s1_advance) begin
            s2_valid_q            <= 1'b1;
            rank_q                <= start;
            value_q               <= s1_value_q;
            flow_oh_q             <= flow_oh;
            finish_q[s1_flow_q]   <= fin;
        end else if (push) begin
            s2_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vtime_q <= '0;
        end else if (deq_valid && (deq_rank > vtime_q)) begin
            vtime_q <= deq_rank;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < FLOWS; f++) begin
                shift_q[f] <= 4'(DEF_SHIFT);
            end
        end else if (cfg_we && (32'(cfg_flow) < FLOWS)) begin
            shift_q[cfg_flow] <= cfg_shift;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.push       = push;
    assign bus.push_rank  = rank_q;
    assign bus.push_value = value_q;
    assign bus.push_flow  = flow_oh_q;

`ifdef STFQ_STATS_EN
    logic [31:0] pkts_q;
    logic [15:0] sat_q;
    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkts_q <= '0;
            sat_q  <= '0;
            drop_q <= '0;
        end else begin
            if (push) begin
                pkts_q <= pkts_q + 32'd1;
            end
            if (s1_advance && fin_sat && (sat_q != 16'hFFFF)) begin
                sat_q <= sat_q + 16'd1;
            end
            if (accept && !flow_ok && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
        end
    end

    assign stat_pkts = pkts_q;
    assign stat_sat  = sat_q;
    assign stat_drop = drop_q;
`endif

endmodule
